staged_reset_sequencer: RTL



---
 rtl/staged_reset_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/staged_reset_sequencer.sv
// N-channel reset/init sequencer: staged reset release, init handshake with timeout,
// and runtime per-channel reset service (local or full re-sequence).
module staged_reset_sequencer #(
  parameter int CHANNELS   = 4,
  parameter int HOLDCYCLES = 16,
  parameter int STAGEGAP   = 8,
  parameter int ACKTIMEOUT = 1024,
  parameter int ESCALATE   = 0
) (
  input  logic                clk,
  input  logic                sync_rst_n,
  input  logic                clk_en,
  input  logic [CHANNELS-1:0] rst_trigger,
  input  logic [CHANNELS-1:0] init_done,
  output logic [CHANNELS-1:0] clk_en_out,
  output logic [CHANNELS-1:0] sync_rst_out,
  output logic [CHANNELS-1:0] init_out,
  output logic [CHANNELS-1:0] timeout_err,
  output logic                busy
);

  localparam int MAXCYC = (HOLDCYCLES > STAGEGAP)
                          ? ((HOLDCYCLES > ACKTIMEOUT) ? HOLDCYCLES : ACKTIMEOUT)
                          : ((STAGEGAP > ACKTIMEOUT) ? STAGEGAP : ACKTIMEOUT);
  localparam int CW = $clog2(MAXCYC + 1);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDCYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGEGAP - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACKTIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_HOLD, S_STAGE, S_INITWAIT, S_RUN, S_LHOLD, S_LINIT
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       svc;
  logic [IW-1:0]       idx_nx;
  logic [IW-1:0]       low_pend;
  logic [CHANNELS-1:0] run;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] ack;
  logic [CHANNELS-1:0] trig_set;

  // Init handshake: init_out[i] is the request, init_done[i] the acknowledge;
  // a transfer happens on an enabled edge where both are high, and it drops the
  // request and starts the channel running. init_done with no request is ignored.
  assign ack        = init_out & init_done;
  assign clk_en_out = {CHANNELS{clk_en}} & run;
  assign busy       = (state != S_RUN);
  assign trig_set   = (state == S_HOLD) ? '0 : rst_trigger;
  assign idx_nx     = idx + 1'b1;

  always_comb begin
    low_pend = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) low_pend = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state        <= S_HOLD;
      cnt          <= '0;
      idx          <= '0;
      svc          <= '0;
      sync_rst_out <= '1;
      init_out     <= '0;
      run          <= '0;
      pending      <= '0;
      timeout_err  <= '0;
    end else begin
      // Triggers latch even while frozen; later per-bit writes take precedence.
      pending <= pending | trig_set;
      if (clk_en) begin
        init_out <= init_out & ~ack;
        run      <= run | ack;
        case (state)
          S_HOLD: begin
            if (cnt == HOLD_LAST) begin
              sync_rst_out[0] <= 1'b0;
              init_out[0]     <= 1'b1;
              idx             <= '0;
              cnt             <= '0;
              state           <= (CHANNELS == 1) ? S_INITWAIT : S_STAGE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_STAGE: begin
            if (cnt == GAP_LAST) begin
              sync_rst_out[idx_nx] <= 1'b0;
              init_out[idx_nx]     <= 1'b1;
              idx                  <= idx_nx;
              cnt                  <= '0;
              if (idx_nx == LAST_IDX) state <= S_INITWAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_INITWAIT: begin
            if (init_out == '0) begin
              state <= S_RUN;
              cnt   <= '0;
            end else if (cnt == ACK_LAST) begin
              // Channels acknowledging on this very edge are not timed out.
              timeout_err  <= timeout_err | (init_out & ~ack);
              sync_rst_out <= sync_rst_out | (init_out & ~ack);
              init_out     <= '0;
              state        <= S_RUN;
              cnt          <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (pending != '0) begin
              cnt <= '0;
              if (ESCALATE != 0) begin
                state        <= S_HOLD;
                idx          <= '0;
                sync_rst_out <= '1;
                run          <= '0;
                init_out     <= '0;
                pending      <= '0;
              end else begin
                state                  <= S_LHOLD;
                svc                    <= low_pend;
                run[low_pend]          <= 1'b0;
                sync_rst_out[low_pend] <= 1'b1;
                pending[low_pend]      <= trig_set[low_pend];
              end
            end
          end
          S_LHOLD: begin
            if (cnt == HOLD_LAST) begin
              sync_rst_out[svc] <= 1'b0;
              init_out[svc]     <= 1'b1;
              state             <= S_LINIT;
              cnt               <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_LINIT: begin
            if (ack[svc]) begin
              state <= S_RUN;
              cnt   <= '0;
            end else if (cnt == ACK_LAST) begin
              timeout_err[svc]  <= 1'b1;
              init_out[svc]     <= 1'b0;
              sync_rst_out[svc] <= 1'b1;
              state             <= S_RUN;
              cnt               <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= S_HOLD;
        endcase
      end
    end
  end

endmodule
